// File: rtl/bcd_glyph_sequencer.sv
// Sequential BCD-to-glyph sequencer: captures DIGITS packed BCD digits and emits one glyph lookup per digit, MSD first.
// Optional leading-zero blanking is enabled by defining BCD_GLYPH_BLANK_LEADING_ZERO_EN.
module bcd_glyph_sequencer #(
    parameter int DIGITS   = 6,
    parameter int ADDR_W   = 2,
    parameter int SEL_W    = 4,
    parameter int SEL_BASE = 4,
    parameter int IDX_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_digits,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_W-1:0]     address_out,
    output logic [SEL_W-1:0]      sel_address_out,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EMIT   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_capture;
    logic [IDX_W-1:0]    r_idx;
    logic                r_err;

    logic                w_emit;
    logic                w_handshake;
    logic                w_blank;
    logic [3:0]          w_digit;
    logic [3:0]          w_nextDigit;
    logic [3:0]          w_firstDigit;
    logic [31:0]         w_selSum;

    // Position 0 is the most significant digit, i.e. the top nibble of the word.
    function automatic logic [3:0] digitAt(input logic [4*DIGITS-1:0] word,
                                           input logic [IDX_W-1:0] pos);
        logic [3:0] d;
        d = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(pos) == DIGITS - 1 - k) begin
                d = word[4*k +: 4];
            end
        end
        return d;
    endfunction

    assign w_emit       = (r_state == ST_EMIT);
    assign w_handshake  = w_emit && out_ready;
    assign w_digit      = digitAt(r_capture, r_idx);
    assign w_nextDigit  = digitAt(r_capture, r_idx + 1'b1);
    assign w_firstDigit = digitAt(bcd_digits, '0);
    assign w_selSum     = SEL_BASE + 32'(w_digit >> ADDR_W);

`ifdef BCD_GLYPH_BLANK_LEADING_ZERO_EN
    logic r_leading;

    // Blank zeros until the first non-zero (or invalid) digit; the last digit always shows.
    assign w_blank = r_leading && (w_digit == 4'd0) && (r_idx != LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_leading <= 1'b0;
        end else if (enable && (r_state == ST_IDLE) && start) begin
            r_leading <= 1'b1;
        end else if (enable && w_handshake) begin
            r_leading <= r_leading && (w_digit == 4'd0);
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        address_out     = '0;
        sel_address_out = '0;
        if (w_emit && (w_digit <= 4'd9) && !w_blank) begin
            address_out     = ADDR_W'(w_digit);
            sel_address_out = SEL_W'(w_selSum);
        end
    end

    assign out_valid = w_emit;
    assign digit_idx = w_emit ? r_idx : '0;
    assign busy      = (r_state == ST_EMIT) || (r_state == ST_FINISH);
    assign done      = (r_state == ST_FINISH);
    assign err       = r_err;

    // err is raised on the edge that first presents an invalid digit, so it is visible alongside it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_capture <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
        end else if (!enable) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_capture <= bcd_digits;
                        r_idx     <= '0;
                        r_err     <= (w_firstDigit > 4'd9);
                        r_state   <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        if (r_idx < LAST_IDX) begin
                            r_idx <= r_idx + 1'b1;
                            if (w_nextDigit > 4'd9) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_glyph_sequencer.sv
// Self-checking bench for bcd_glyph_sequencer: expected glyphs are queued on start and popped per handshake.
module tb_bcd_glyph_sequencer;

    localparam int DIGITS   = 6;
    localparam int ADDR_W   = 2;
    localparam int SEL_W    = 4;
    localparam int SEL_BASE = 4;
    localparam int IDX_W    = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                start;
    logic [4*DIGITS-1:0] bcd_digits;
    logic                out_ready;
    logic                out_valid;
    logic [ADDR_W-1:0]   address_out;
    logic [SEL_W-1:0]    sel_address_out;
    logic [IDX_W-1:0]    digit_idx;
    logic                busy;
    logic                done;
    logic                err;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic              bad;
    } glyph_t;

    glyph_t expQ[$];
    int assertCount = 0;
    int failCount   = 0;

    bcd_glyph_sequencer #(
        .DIGITS(DIGITS), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .SEL_BASE(SEL_BASE), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .bcd_digits(bcd_digits),
        .out_ready(out_ready), .out_valid(out_valid), .address_out(address_out),
        .sel_address_out(sel_address_out), .digit_idx(digit_idx), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic glyph_t modelGlyph(input logic [3:0] d, input int pos, input bit leading);
        glyph_t g;
        g.idx = IDX_W'(pos);
        g.bad = (d > 4'd9);
        if (g.bad) begin
            g.sel  = '0;
            g.addr = '0;
        end else begin
            g.addr = ADDR_W'(d % (2**ADDR_W));
            g.sel  = SEL_W'(SEL_BASE + d / (2**ADDR_W));
        end
`ifdef BCD_GLYPH_BLANK_LEADING_ZERO_EN
        if (leading && d == 4'd0 && pos != DIGITS - 1) begin
            g.sel  = '0;
            g.addr = '0;
        end
`else
        if (leading) begin
            g.bad = g.bad;
        end
`endif
        return g;
    endfunction

    task automatic pushFrame(input logic [4*DIGITS-1:0] word);
        bit leading;
        logic [3:0] d;
        leading = 1'b1;
        for (int pos = 0; pos < DIGITS; pos++) begin
            d = word[4*(DIGITS-1-pos) +: 4];
            expQ.push_back(modelGlyph(d, pos, leading));
            if (d != 4'd0) leading = 1'b0;
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, ".valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, ".busy"},  32'(busy), 32'd0);
        checkOutput({name, ".done"},  32'(done), 32'd0);
        checkOutput({name, ".addr"},  32'(address_out), 32'd0);
        checkOutput({name, ".sel"},   32'(sel_address_out), 32'd0);
    endtask

    // Runs one full frame; stall=1 applies the ready pattern 1,0,0,1,0,0,...
    task automatic applyStimulus(input logic [4*DIGITS-1:0] word, input bit stall, input string name);
        int cyc;
        int hs;
        bit sawDone;
        bit errSoFar;
        bit anyBad;
        glyph_t front;
        expQ.delete();
        pushFrame(word);
        anyBad = 1'b0;
        foreach (expQ[i]) anyBad |= expQ[i].bad;
        @(negedge clk);
        bcd_digits = word;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        hs       = 0;
        sawDone  = 1'b0;
        errSoFar = 1'b0;
        while (!sawDone && cyc < 200) begin
            out_ready = stall ? (cyc % 3 == 1) : 1'b1;
            if (out_valid) begin
                checkOutput({name, ".noOverrun"}, 32'(hs < DIGITS), 32'd1);
                if (expQ.size() > 0) begin
                    front = expQ[0];
                    checkOutput({name, ".idx"},  32'(digit_idx), 32'(front.idx));
                    checkOutput({name, ".sel"},  32'(sel_address_out), 32'(front.sel));
                    checkOutput({name, ".addr"}, 32'(address_out), 32'(front.addr));
                    checkOutput({name, ".err"},  32'(err), 32'(errSoFar | front.bad));
                    checkOutput({name, ".busy"}, 32'(busy), 32'd1);
                    checkOutput({name, ".done"}, 32'(done), 32'd0);
                    if (out_ready) begin
                        errSoFar |= front.bad;
                        void'(expQ.pop_front());
                        hs++;
                    end
                end
            end else if (done) begin
                sawDone = 1'b1;
                checkOutput({name, ".handshakes"}, 32'(hs), 32'(DIGITS));
                checkOutput({name, ".queueEmpty"}, 32'(expQ.size()), 32'd0);
                checkOutput({name, ".errAtDone"}, 32'(err), 32'(anyBad));
                checkOutput({name, ".busyAtDone"}, 32'(busy), 32'd1);
                if (!stall) checkOutput({name, ".doneCycle"}, 32'(cyc), 32'(DIGITS + 1));
            end else begin
                checkOutput({name, ".validGap"}, 32'(out_valid), 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, ".finished"}, 32'(sawDone), 32'd1);
        checkIdle({name, ".after"});
        checkOutput({name, ".errHeld"}, 32'(err), 32'(anyBad));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b0;
        bcd_digits = '0;
        repeat (2) @(negedge clk);
        checkIdle("reset");
        checkOutput("reset.idx", 32'(digit_idx), 32'd0);
        checkOutput("reset.err", 32'(err), 32'd0);
        reset = 1'b1;

        applyStimulus(24'h123059, 1'b0, "basic");
        applyStimulus(24'h123059, 1'b1, "stall");
        applyStimulus(24'h12A459, 1'b0, "invalid");
        applyStimulus(24'h000000, 1'b0, "zeros");

        // Restart while busy is ignored; dropping enable aborts without a done pulse.
        expQ.delete();
        pushFrame(24'h123059);
        @(negedge clk);
        bcd_digits = 24'h123059;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bcd_digits = 24'h987654;
        start      = 1'b1;
        checkOutput("abort.sel2", 32'(sel_address_out), 32'(expQ[2].sel));
        checkOutput("abort.addr2", 32'(address_out), 32'(expQ[2].addr));
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort.idx3", 32'(digit_idx), 32'd3);
        checkOutput("abort.sel3", 32'(sel_address_out), 32'(expQ[3].sel));
        checkOutput("abort.addr3", 32'(address_out), 32'(expQ[3].addr));
        enable = 1'b0;
        @(negedge clk);
        checkIdle("abort.off");
        @(negedge clk);
        checkIdle("abort.noDone");
        expQ.delete();

        // start while disabled must not launch a sequence
        bcd_digits = 24'h123059;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkIdle("disabledStart");
        enable = 1'b1;
        @(negedge clk);
        checkIdle("disabledStart.later");

        // Reset in the middle of a frame, after err has been raised
        bcd_digits = 24'h12A459;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("midReset.errBefore", 32'(err), 32'd1);
        checkOutput("midReset.idxBefore", 32'(digit_idx), 32'd2);
        reset = 1'b0;
        @(negedge clk);
        checkIdle("midReset");
        checkOutput("midReset.idx", 32'(digit_idx), 32'd0);
        checkOutput("midReset.err", 32'(err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midReset.noDone", 32'(done), 32'd0);

        applyStimulus(24'h123059, 1'b0, "afterReset");
        applyStimulus(24'h000705, 1'b0, "leadZero");
        applyStimulus(24'h000000, 1'b1, "allZeroStall");
        applyStimulus(24'h9F0010, 1'b1, "mixedStall");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_glyph_sequencer.md
Name: bcd_glyph_sequencer

Overview:
- Sequential, parametrised successor to the combinational BCD-to-glyph decoder used on the RTC display path.
- Captures a packed word of DIGITS BCD digits, e.g. hh:mm:ss, on a start pulse.
- Emits one glyph lookup per digit, most significant digit first, to the character ROM/VGA renderer under a valid/ready handshake. Each lookup is a bank select plus an in-bank address.
- Flags non-BCD digits and reports completion.

Parameters:
- DIGITS, 6: number of BCD digits per frame; 1..16.
- ADDR_W, 2: glyph in-bank address width; glyphs per bank = 2**ADDR_W.
- SEL_W, 4: bank select width.
- SEL_BASE, 4: bank select value for digit 0.
- IDX_W, 3: digit index width; must be >= max(1, clog2(DIGITS)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  block enable; low aborts any sequence and forces outputs to zero.
- start  input  1  single-cycle request to capture bcd_digits.
- bcd_digits  input  4*DIGITS  packed BCD. Digit k sits at bits [4k+3:4k]; digit DIGITS-1 is most significant.
- out_ready  input  1  downstream accepts the current lookup.
- out_valid  output  1  address_out, sel_address_out and digit_idx are valid.
- address_out  output  ADDR_W  glyph address within the bank.
- sel_address_out  output  SEL_W  glyph bank select.
- digit_idx  output  IDX_W  position of the emitted digit; 0 = most significant.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse after the last handshake.
- err  output  1  sticky: at least one captured digit was > 9.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE. out_valid, address_out, sel_address_out, digit_idx, busy, done and err all = 0. Capture register cleared.
- States are IDLE, EMIT and FINISH.
- IDLE:
  - start=1 and enable=1 at an edge: capture bcd_digits, clear err, digit_idx=0, busy=1, go to EMIT.
  - out_valid rises on the cycle after start (latency 1).
- EMIT:
  - Outputs reflect the digit d at position digit_idx.
  - For d <= 9: address_out = d mod 2**ADDR_W; sel_address_out = SEL_BASE + (d >> ADDR_W), truncated to SEL_W.
  - For d > 9: address_out=0, sel_address_out=0, err set at the same edge the digit is first presented. The digit is still emitted and handshaken.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready at an edge:
    - if digit_idx < DIGITS-1, increment digit_idx and present the next digit in the following cycle. Back-to-back handshakes give one digit per cycle.
    - otherwise go to FINISH.
- FINISH: out_valid=0, done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE. err holds its value until the next accepted start.
- start while busy=1: ignored; the captured word is not modified.
- enable=0 in any state: next edge goes to IDLE. out_valid, busy, address_out and sel_address_out go to 0; no done pulse; err keeps its value.
- start with enable=0: ignored.
- Reset mid-sequence: immediate return to reset values at that edge; no done pulse.
- DIGITS=1: a single handshake leads directly to FINISH.

Optional Feature:
- Macro: BCD_GLYPH_BLANK_LEADING_ZERO_EN.
- Defined:
  - Leading zero digits, i.e. zeros before the first non-zero digit, are still emitted and handshaken, but with address_out=0 and sel_address_out=0 (blank glyph).
  - The least significant digit is never blanked, so a value of 0 shows "0".
  - Invalid digits end blanking.
- Undefined: every digit is decoded normally and there is no blanking logic.

Test Plan:
- DIGITS=6, bcd_digits=0x123059, out_ready held 1, one start pulse:
  - out_valid for cycles 1..6.
  - (sel,addr) sequence = (4,1),(4,2),(4,3),(4,0),(5,1),(6,1); digit_idx 0..5.
  - done pulses at cycle 7; err=0.
- Same word with out_ready toggling 1,0,0,1,...: outputs are stable during stalls, no digit is skipped or duplicated, and exactly 6 handshakes occur before done.
- bcd_digits=0x12A459 → third lookup is (0,0), err=1 from that cycle through FINISH; a new start with 0x000000 clears err.
- Assert start again at cycle 3 with a different word → ignored. Drop enable at cycle 4 → out_valid=0 and busy=0 next cycle, no done pulse.
- reset=0 during EMIT → all outputs 0 at the next edge. A start after reset release sequences correctly from digit 0.
- With BCD_GLYPH_BLANK_LEADING_ZERO_EN defined:
  - 0x000705 → (0,0),(0,0),(0,0),(5,3),(4,0),(5,1).
  - 0x000000 → five blanks, then (4,0).
